// File: rtl/mem_split_arbiter_if.sv
// Split-transaction memory port: request channel plus in-order read response.
// Signals:
//   req/we/addr/wdata/be : request valid and payload, held stable until ack
//   ack                  : request accepted this cycle
//   resp/rdata           : read response strobe and data
// Modports:
//   master : issues requests (host side, or the arbiter facing the target)
//   slave  : accepts requests (target side, or the arbiter facing a host)
interface mem_split_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, resp, rdata
    );
endinterface

// File: rtl/mem_split_arbiter.sv
// 2-to-1 round-robin arbiter merging two split-transaction hosts onto one
// target; read responses are steered back through an order FIFO of host IDs.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   m0, m1       : host ports (slave modport)
//   target       : merged target port (master modport)
//   err_o        : sticky protocol error, only with ARB_ERR_CHECK_EN defined
// Parameter ORDER_FIFO_POW: log2 of max outstanding reads.
module mem_split_arbiter #(
    parameter int ORDER_FIFO_POW = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_split_arbiter_if.slave  m0,
    mem_split_arbiter_if.slave  m1,
    mem_split_arbiter_if.master target
`ifdef ARB_ERR_CHECK_EN
    ,
    output logic                err_o
`endif
);

    localparam int DEPTH = 1 << ORDER_FIFO_POW;
    localparam int CNT_W = ORDER_FIFO_POW + 1;

    logic                      lock_valid;
    logic                      lock_id;
    logic                      rr_ptr;

    logic [DEPTH-1:0]          order_q;
    logic [ORDER_FIFO_POW-1:0] wr_ptr;
    logic [ORDER_FIFO_POW-1:0] rd_ptr;
    logic [CNT_W-1:0]          count;

    logic                      grant;
    logic                      g_req;
    logic                      g_we;
    logic [31:0]               g_addr;
    logic [31:0]               g_wdata;
    logic [3:0]                g_be;

    logic                      full;
    logic                      empty;
    logic                      blocked;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      head;

    // Lock wins; a lone requester wins; a tie (or idle) falls to rr_ptr.
    always_comb begin
        grant = rr_ptr;
        if (lock_valid) begin
            grant = lock_id;
        end else if (m0.req != m1.req) begin
            grant = m1.req;
        end
    end

    assign g_req   = grant ? m1.req   : m0.req;
    assign g_we    = grant ? m1.we    : m0.we;
    assign g_addr  = grant ? m1.addr  : m0.addr;
    assign g_wdata = grant ? m1.wdata : m0.wdata;
    assign g_be    = grant ? m1.be    : m0.be;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A read with no room to record its host ID is held off; a same-cycle
    // pop is not forwarded, so space only appears the cycle after.
    assign blocked = !g_we && full;

    assign target.req   = g_req && !blocked && !rst_i;
    assign target.we    = g_we;
    assign target.addr  = g_addr;
    assign target.wdata = g_wdata;
    assign target.be    = g_be;

    assign accept = target.req && target.ack;
    assign push   = accept && !g_we;
    assign pop    = target.resp && !empty;
    assign head   = order_q[rd_ptr];

    assign m0.ack   = accept && !grant;
    assign m1.ack   = accept && grant;
    assign m0.resp  = pop && !head;
    assign m1.resp  = pop && head;
    assign m0.rdata = target.rdata;
    assign m1.rdata = target.rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            rr_ptr     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (accept) begin
                lock_valid <= 1'b0;
                rr_ptr     <= ~grant;
            end else if (target.req) begin
                lock_valid <= 1'b1;
                lock_id    <= grant;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ID storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            order_q[wr_ptr] <= grant;
        end
    end

`ifdef ARB_ERR_CHECK_EN
    logic        lock_we;
    logic [31:0] lock_addr;

    // Snapshot of the stalled request, taken when the lock is first set.
    always_ff @(posedge clk_i) begin
        if (!lock_valid && target.req && !target.ack) begin
            lock_we   <= g_we;
            lock_addr <= g_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (target.resp && empty) begin
            err_o <= 1'b1;
        end else if (lock_valid &&
                     (!g_req || g_we != lock_we || g_addr != lock_addr)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_split_arbiter.sv
// Self-checking bench for mem_split_arbiter: directed scenarios plus a
// randomized phase, compared against a queue-based reference model.
module tb_mem_split_arbiter;

    localparam int POW   = 2;
    localparam int DEPTH = 1 << POW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_split_arbiter_if h0 ();
    mem_split_arbiter_if h1 ();
    mem_split_arbiter_if tgt ();

`ifdef ARB_ERR_CHECK_EN
    logic err;
`endif

    mem_split_arbiter #(.ORDER_FIFO_POW(POW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .m0     (h0),
        .m1     (h1),
        .target (tgt)
`ifdef ARB_ERR_CHECK_EN
        ,
        .err_o  (err)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: outstanding read owners, lock and priority.
    int          q[$];
    bit          m_lock;
    bit          m_lock_id;
    bit          m_rr;
    bit          m_lock_we;
    logic [31:0] m_lock_addr;
    bit          m_err;

    bit          s_grant;
    bit          s_treq;
    bit          s_acc;
    bit          s_we;
    bit          s_pop;
    bit          s_errset;
    logic [31:0] s_addr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_h(input int n, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        if (n == 0) begin
            h0.req = req; h0.we = we; h0.addr = addr;
            h0.wdata = wdata; h0.be = be;
        end else begin
            h1.req = req; h1.we = we; h1.addr = addr;
            h1.wdata = wdata; h1.be = be;
        end
    endtask

    task automatic sample();
        bit          g;
        bit          greq;
        bit          gwe;
        logic [31:0] ga;
        logic [31:0] gd;
        logic [3:0]  gb;
        bit          treq;
        bit          acc;
        bit          pop;
        @(negedge clk);
        if (m_lock) g = m_lock_id;
        else if (h0.req && !h1.req) g = 1'b0;
        else if (h1.req && !h0.req) g = 1'b1;
        else g = m_rr;
        greq = g ? h1.req   : h0.req;
        gwe  = g ? h1.we    : h0.we;
        ga   = g ? h1.addr  : h0.addr;
        gd   = g ? h1.wdata : h0.wdata;
        gb   = g ? h1.be    : h0.be;
        treq = !rst && greq && !(!gwe && q.size() == DEPTH);
        acc  = treq && tgt.ack;
        pop  = tgt.resp && q.size() > 0;
        chk("target_req", tgt.req, treq);
        if (treq) begin
            chk("target_we", tgt.we, gwe);
            chk("target_addr", tgt.addr, ga);
            chk("target_wdata", tgt.wdata, gd);
            chk("target_be", tgt.be, gb);
        end
        chk("m0_ack", h0.ack, acc && !g);
        chk("m1_ack", h1.ack, acc && g);
        chk("m0_resp", h0.resp, pop && q[0] == 0);
        chk("m1_resp", h1.resp, pop && q[0] == 1);
        chk("m0_rdata", h0.rdata, tgt.rdata);
        chk("m1_rdata", h1.rdata, tgt.rdata);
`ifdef ARB_ERR_CHECK_EN
        chk("err_o", err, m_err);
`endif
        s_grant  = g;
        s_treq   = treq;
        s_acc    = acc;
        s_we     = gwe;
        s_pop    = pop;
        s_addr   = ga;
        s_errset = (tgt.resp && q.size() == 0) ||
                   (m_lock && (!greq || gwe != m_lock_we ||
                               ga != m_lock_addr));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_lock = 1'b0;
            m_rr   = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (s_pop) void'(q.pop_front());
            if (s_acc && !s_we) q.push_back(int'(s_grant));
            if (s_acc) begin
                m_lock = 1'b0;
                m_rr   = !s_grant;
            end else if (s_treq) begin
                m_lock      = 1'b1;
                m_lock_id   = s_grant;
                m_lock_we   = s_we;
                m_lock_addr = s_addr;
            end
            if (s_errset) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    bit          pend[2];
    logic [31:0] rv;

    initial begin
        set_h(0, 0, 0, 0, 0, 0);
        set_h(1, 0, 0, 0, 0, 0);
        tgt.ack = 0; tgt.resp = 0; tgt.rdata = 0;
        m_lock = 0; m_lock_id = 0; m_rr = 0;
        m_lock_we = 0; m_lock_addr = 0; m_err = 0;

        // Reset state
        rst = 1'b1;
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        sample();
        chk("rst_treq", tgt.req, 0);
        chk("rst_resp", {h0.resp, h1.resp}, 0);
        advance();

        // Single read from m0, response three cycles later
        set_h(0, 1, 0, 32'h100, 0, 4'hF);
        tgt.ack = 1;
        sample();
        chk("t1_addr", tgt.addr, 32'h100);
        chk("t1_ack", h0.ack, 1);
        advance();
        set_h(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        tgt.resp = 1; tgt.rdata = 32'hDEADBEEF;
        sample();
        chk("t1_m0_resp", h0.resp, 1);
        chk("t1_m0_rdata", h0.rdata, 32'hDEADBEEF);
        chk("t1_m1_resp", h1.resp, 0);
        advance();
        tgt.resp = 0;

        // Both hosts read from the same cycle
        do_reset();
        set_h(0, 1, 0, 32'h10, 0, 4'hF);
        set_h(1, 1, 0, 32'h20, 0, 4'hF);
        tgt.ack = 1;
        sample();
        chk("t2_c0_m0_ack", h0.ack, 1);
        chk("t2_c0_addr", tgt.addr, 32'h10);
        advance();
        set_h(0, 0, 0, 0, 0, 0);
        sample();
        chk("t2_c1_m1_ack", h1.ack, 1);
        chk("t2_c1_addr", tgt.addr, 32'h20);
        advance();
        set_h(1, 0, 0, 0, 0, 0);
        tgt.resp = 1; tgt.rdata = 32'h11;
        sample();
        chk("t2_r0_m0", h0.resp, 1);
        chk("t2_r0_m1", h1.resp, 0);
        chk("t2_r0_data", h0.rdata, 32'h11);
        advance();
        tgt.rdata = 32'h22;
        sample();
        chk("t2_r1_m1", h1.resp, 1);
        chk("t2_r1_m0", h0.resp, 0);
        chk("t2_r1_data", h1.rdata, 32'h22);
        advance();
        tgt.resp = 0;

        // Stalled write keeps the grant locked to m0
        set_h(0, 1, 1, 32'h40, 32'hCAFE, 4'hF);
        tgt.ack = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_h(1, 1, 0, 32'h80, 0, 4'h3);
            if (c == 3) tgt.ack = 1;
            sample();
            chk("t3_addr", tgt.addr, 32'h40);
            chk("t3_wdata", tgt.wdata, 32'hCAFE);
            chk("t3_m0_ack", h0.ack, (c == 3));
            chk("t3_m1_ack", h1.ack, 0);
            advance();
        end
        set_h(0, 0, 0, 0, 0, 0);
        sample();
        chk("t3_c4_m1_ack", h1.ack, 1);
        chk("t3_c4_addr", tgt.addr, 32'h80);
        advance();
        set_h(1, 0, 0, 0, 0, 0);
        tgt.resp = 1; tgt.rdata = 32'h80;
        sample();
        chk("t3_m1_resp", h1.resp, 1);
        advance();
        tgt.resp = 0;

        // Order FIFO full blocks a fifth read
        for (int i = 0; i < 4; i++) begin
            set_h(0, 1, 0, 32'h200 + 32'(4 * i), 0, 4'hF);
            sample();
            chk("t4_fill_ack", h0.ack, 1);
            advance();
        end
        set_h(0, 1, 0, 32'h210, 0, 4'hF);
        sample();
        chk("t4_blk_treq", tgt.req, 0);
        chk("t4_blk_ack", h0.ack, 0);
        advance();
        set_h(1, 1, 1, 32'h300, 32'h5, 4'h1);
        sample();
        chk("t4_m1_wr_ack", h1.ack, 1);
        chk("t4_m0_ack", h0.ack, 0);
        advance();
        set_h(1, 0, 0, 0, 0, 0);
        tgt.resp = 1; tgt.rdata = 32'h55;
        sample();
        chk("t4_pop_m0_resp", h0.resp, 1);
        chk("t4_pop_treq", tgt.req, 0);
        advance();
        tgt.resp = 0;
        sample();
        chk("t4_after_ack", h0.ack, 1);
        advance();
        set_h(0, 0, 0, 0, 0, 0);
        tgt.resp = 1;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            tgt.rdata = $urandom;
            cyc();
        end
        tgt.resp = 0;
        chk("t4_drained", q.size(), 0);

        // Randomized traffic obeying the host protocol
        pend[0] = 0; pend[1] = 0;
        for (int i = 0; i < 450; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && i < 400 && $urandom_range(0, 2) == 0) begin
                    pend[n] = 1;
                    rv = $urandom;
                    set_h(n, 1, rv[0], $urandom, $urandom, rv[7:4]);
                end else if (!pend[n]) begin
                    set_h(n, 0, 0, 0, 0, 0);
                end
            end
            tgt.ack   = (i >= 400) || ($urandom_range(0, 3) != 0);
            tgt.resp  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            tgt.rdata = $urandom;
            cyc();
            if (s_acc) pend[s_grant] = 0;
        end
        chk("rnd_idle", {30'd0, pend[1], pend[0]}, 0);
        set_h(0, 0, 0, 0, 0, 0);
        set_h(1, 0, 0, 0, 0, 0);
        tgt.resp = 1;
        for (int i = 0; i < 16 && q.size() > 0; i++) begin
            tgt.rdata = $urandom;
            cyc();
        end
        tgt.resp = 0;

        // Reset discards outstanding reads; late responses are dropped
        tgt.ack = 1;
        set_h(0, 1, 0, 32'h400, 0, 4'hF);
        cyc();
        set_h(0, 1, 0, 32'h404, 0, 4'hF);
        cyc();
        set_h(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        sample();
        chk("t5_rst_treq", tgt.req, 0);
        advance();
        rst = 1'b0;
        tgt.resp = 1; tgt.rdata = 32'h77;
        sample();
        chk("t5_m0_resp", h0.resp, 0);
        chk("t5_m1_resp", h1.resp, 0);
        advance();
        tgt.resp = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
`ifdef ARB_ERR_CHECK_EN
            chk("t5_err_sticky", err, 1);
`endif
            advance();
        end
        do_reset();
        sample();
`ifdef ARB_ERR_CHECK_EN
        chk("t5_err_clear", err, 0);
`endif
        chk("t5_idle_treq", tgt.req, 0);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_split_arbiter.md
Name: mem_split_arbiter

Overview:
- 2-to-1 arbiter merging two split-transaction memory hosts onto one target port. Intended use: CPU instruction and data ports sharing one memory in a unified-memory test wrapper.
- Request channel (req/ack/we/addr/wdata/be) is arbitrated round-robin, with the grant locked while a request is stalled.
- Read responses (resp/rdata) return in order. They are routed back to the issuing host through an order FIFO of host IDs.
- Writes produce no response.

Parameters:
ORDER_FIFO_POW, 3, log2 of order FIFO depth (max outstanding reads = 2**ORDER_FIFO_POW)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
m0_req  in  1  host 0 request valid
m0_we  in  1  host 0 write enable
m0_addr  in  32  host 0 address
m0_wdata  in  32  host 0 write data
m0_be  in  4  host 0 byte enables
m0_ack  out  1  host 0 request accepted
m0_resp  out  1  host 0 read response valid
m0_rdata  out  32  host 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_ack, m1_resp, m1_rdata: same as m0_*, for host 1
target_req  out  1  merged request valid
target_we  out  1  merged write enable
target_addr  out  32  merged address
target_wdata  out  32  merged write data
target_be  out  4  merged byte enables
target_ack  in  1  target accepted request
target_resp  in  1  target read response valid
target_rdata  in  32  target read data

Behaviour:
- Handshake: a request transfers in a cycle where req && ack. A host holds req/we/addr/wdata/be stable until acked. The target returns exactly one resp per accepted read, in order, and none for writes.
- Grant select (combinational):
  - Locked: grant = lock_id.
  - Otherwise, if only one host requests, that host wins.
  - Otherwise, if both request, the host equal to rr_ptr wins.
- Read blocking: if the granted request is a read (we=0) and the FIFO is full (count == 2**ORDER_FIFO_POW), that request is blocked. target_req=0 and no ack is given. There is no pass-through: a pop in the same cycle does not free space until the next cycle.
- target_* request outputs carry the granted host's signals when target_req=1. Otherwise target_req=0 and the other fields are don't-care, driven as the granted host's values.
- mN_ack = target_ack && target_req && (grant==N). The ack is combinational from target_ack.
- Lock register:
  - Set: target_req && !target_ack sets lock_valid=1 and lock_id=grant.
  - Clear: lock_valid clears on an accepted handshake.
  - The locked host keeps ownership even if the other host requests.
- rr_ptr: on every accepted handshake, rr_ptr <= ~grant (the other host gets priority next).
- Order FIFO:
  - Push: push grant ID on an accepted read.
  - Pop: pop on target_resp.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo depth.
- Response routing:
  - mN_resp = target_resp && !empty && (head==N).
  - m0_rdata = m1_rdata = target_rdata (broadcast); the valid strobe is resp only.
- target_resp with an empty FIFO: dropped, no pop, no host resp.
- Reset (rst_i=1 at a clock edge):
  - FIFO emptied (rd/wr pointers=0, count=0); lock_valid=0; rr_ptr=0 (host 0 preferred).
  - Outputs after reset with no host requests: target_req=0, m0_ack=m1_ack=0, m0_resp=m1_resp=0.
  - Reset mid-operation discards outstanding read IDs. Later responses for them are dropped per the empty-FIFO rule.
  - While rst_i=1, target_req and acks are forced 0.

Optional Feature:
ARB_ERR_CHECK_EN
- Defined:
  - Adds output err_o (1 bit), registered and sticky, reset to 0.
  - err_o is set by target_resp while the FIFO is empty.
  - err_o is set by host req being dropped or its we/addr changing while that host is locked and unacked.
  - err_o is cleared only by rst_i.
- Undefined: no err_o port and no checking logic; behaviour is otherwise identical.

Test Plan:
- After reset, m0 read addr 0x0000_0100, target_ack=1 immediately:
  - Same cycle: target_addr=0x100, m0_ack=1.
  - 3 cycles later target_resp=1, rdata=0xDEADBEEF -> m0_resp=1, m0_rdata=0xDEADBEEF, m1_resp=0.
- m0 and m1 both read from cycle 0 (addr 0x10, 0x20), target_ack always 1:
  - m0 granted cycle 0, m1 granted cycle 1.
  - Responses 0x11 then 0x22 -> m0_resp with 0x11, then m1_resp with 0x22.
- m0 write 0x40/0xCAFE/be=0xF with target_ack=0 for 3 cycles, m1 req raised in cycle 1:
  - target_* holds m0 values for all 4 cycles; m0_ack on cycle 3.
  - m1 granted cycle 4.
  - FIFO count stays 0 (write).
- ORDER_FIFO_POW=2, m0 issues 4 reads with no resp, then a 5th read:
  - 5th read: target_req=0, m0_ack=0.
  - m1 write is accepted meanwhile.
  - After 1 target_resp (routed to m0), the 5th read is accepted the following cycle.
- 2 reads outstanding, rst_i pulsed 1 cycle, then target_resp=1:
  - No m0_resp/m1_resp.
  - With ARB_ERR_CHECK_EN: err_o=1 the cycle after and it stays 1 until the next reset.
